// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: opcodes, FSM states,
// hazard_type encodings and the per-opcode source-register decode.
package hazard_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_LLI  = 4'b1010;
  localparam logic [3:0] OP_LHI  = 4'b1011;
  localparam logic [3:0] OP_B    = 4'b1100;
  localparam logic [3:0] OP_BR   = 4'b1101;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CTRL    = 3'd1,
    RELEASE = 3'd2,
    DRAIN   = 3'd3,
    HALTED  = 3'd4
  } hz_state_e;

  localparam logic [1:0] HZ_NONE = 2'b00;
  localparam logic [1:0] HZ_LOAD = 2'b01;
  localparam logic [1:0] HZ_CTRL = 2'b10;
  localparam logic [1:0] HZ_HALT = 2'b11;

  typedef struct packed {
    logic rd;
    logic rs;
    logic rt;
  } src_use_t;

  // rd doubles as a source for the store-data and load-immediate-into-half forms.
  function automatic src_use_t src_use(input logic [3:0] op);
    src_use_t u;
    u.rs = (op <= OP_SW) || (op == OP_BR);
    u.rt = (op <= OP_OR) || (op == OP_XOR);
    u.rd = (op == OP_SW) || (op == OP_LLI) || (op == OP_LHI);
    return u;
  endfunction

endpackage

// File: rtl/hazard_stall_ctr.sv
// Loadable down-counter holding the remaining stall count; decrements
// saturate at zero and zero_o flags an empty count.
module hazard_stall_ctr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/hazard_unit_p.sv
// Load-use detection plus branch/halt stall sequencing for the 5-stage core.
// Define HAZARD_PERF_CNT_EN to add saturating load/control stall counters.
module hazard_unit_p
  import hazard_pkg::*;
#(
  parameter int INSTR_W    = 16,
  parameter int REG_AW     = 4,
  parameter int BR_PENALTY = 2,
  parameter int HLT_DRAIN  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] if_id_instr,
  input  logic               if_id_valid,
  input  logic [INSTR_W-1:0] id_ex_instr,
  input  logic               id_ex_memread,
  input  logic               id_ex_valid,
  output logic               stall,
  output logic               id_ex_bubble,
  output logic [1:0]         hazard_type,
  output logic [2:0]         cycle_number,
  output logic               halted,
`ifdef HAZARD_PERF_CNT_EN
  output logic [15:0]        load_stall_cnt,
  output logic [15:0]        ctrl_stall_cnt,
`endif
  output logic [2:0]         dbg_state
);

  localparam int BR_LOAD_I  = (BR_PENALTY > 0) ? BR_PENALTY - 1 : 0;
  localparam int HLT_LOAD_I = (HLT_DRAIN > 0) ? HLT_DRAIN - 1 : 0;
  localparam logic [2:0] BR_LOAD  = BR_LOAD_I[2:0];
  localparam logic [2:0] HLT_LOAD = HLT_LOAD_I[2:0];

  logic [3:0]        if_op;
  logic [REG_AW-1:0] if_rd, if_rs, if_rt, ex_rd;
  src_use_t          use_v;
  logic              load_use;
  logic              is_branch, is_halt;
  logic              unused_ex;

  assign if_op = if_id_instr[INSTR_W-1 -: 4];
  assign if_rd = if_id_instr[3*REG_AW-1 -: REG_AW];
  assign if_rs = if_id_instr[2*REG_AW-1 -: REG_AW];
  assign if_rt = if_id_instr[REG_AW-1:0];
  assign ex_rd = id_ex_instr[3*REG_AW-1 -: REG_AW];
  assign unused_ex = ^{id_ex_instr[INSTR_W-1:3*REG_AW], id_ex_instr[2*REG_AW-1:0]};

  assign use_v = src_use(if_op);

  assign load_use = if_id_valid & id_ex_valid & id_ex_memread & (ex_rd != '0) &
                    ((use_v.rd & (if_rd == ex_rd)) |
                     (use_v.rs & (if_rs == ex_rd)) |
                     (use_v.rt & (if_rt == ex_rd)));

  assign is_branch = if_id_valid & ((if_op == OP_B) | (if_op == OP_BR));
  assign is_halt   = if_id_valid & (if_op == OP_HLT);

  hz_state_e  state_q, state_d;
  logic       halted_q;
  logic       ctr_load, ctr_dec, ctr_zero;
  logic [2:0] ctr_val, ctr_count, cnt_rem;

  hazard_stall_ctr #(.W(3)) u_ctr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ctr_load),
    .load_val_i (ctr_val),
    .dec_i      (ctr_dec),
    .count_o    (ctr_count),
    .zero_o     (ctr_zero)
  );

  // The counter holds stall cycles left including the current one, so the
  // reported "remaining after this cycle" is one less.
  assign cnt_rem = ctr_zero ? 3'd0 : ctr_count - 3'd1;

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    hazard_type  = HZ_NONE;
    cycle_number = 3'd0;
    ctr_load     = 1'b0;
    ctr_val      = 3'd0;
    ctr_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_use) begin
          stall       = 1'b1;
          hazard_type = HZ_LOAD;
        end else if (is_branch && (BR_PENALTY > 0)) begin
          stall        = 1'b1;
          hazard_type  = HZ_CTRL;
          ctr_load     = 1'b1;
          ctr_val      = BR_LOAD;
          cycle_number = BR_LOAD;
          state_d      = (BR_LOAD != 3'd0) ? CTRL : RELEASE;
        end else if (is_halt) begin
          stall        = 1'b1;
          hazard_type  = HZ_HALT;
          ctr_load     = 1'b1;
          ctr_val      = HLT_LOAD;
          cycle_number = HLT_LOAD;
          state_d      = (HLT_LOAD != 3'd0) ? DRAIN : HALTED;
        end
      end
      CTRL: begin
        stall        = 1'b1;
        hazard_type  = HZ_CTRL;
        ctr_dec      = 1'b1;
        cycle_number = cnt_rem;
        if (cnt_rem == 3'd0) state_d = RELEASE;
      end
      RELEASE: begin
        if (load_use) begin
          stall       = 1'b1;
          hazard_type = HZ_LOAD;
        end
        state_d = IDLE;
      end
      DRAIN: begin
        stall        = 1'b1;
        hazard_type  = HZ_HALT;
        ctr_dec      = 1'b1;
        cycle_number = cnt_rem;
        if (cnt_rem == 3'd0) state_d = HALTED;
      end
      HALTED: begin
        stall       = 1'b1;
        hazard_type = HZ_HALT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALTED);
    end
  end

  assign id_ex_bubble = stall;
  assign halted       = halted_q;
  assign dbg_state    = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] load_cnt_q, ctrl_cnt_q;
  logic        load_inc, ctrl_inc;

  // Halt drain counts as a control stall; the parked HALTED cycles do not.
  assign load_inc = stall & (hazard_type == HZ_LOAD);
  assign ctrl_inc = stall & (hazard_type != HZ_LOAD) & (state_q != HALTED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt_q <= 16'd0;
      ctrl_cnt_q <= 16'd0;
    end else begin
      if (load_inc && (load_cnt_q != 16'hFFFF)) load_cnt_q <= load_cnt_q + 16'd1;
      if (ctrl_inc && (ctrl_cnt_q != 16'hFFFF)) ctrl_cnt_q <= ctrl_cnt_q + 16'd1;
    end
  end

  assign load_stall_cnt = load_cnt_q;
  assign ctrl_stall_cnt = ctrl_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit_p.sv
// Bench for hazard_unit_p: directed scenarios then random traffic, checked
// against a stall-schedule queue model. A second instance has BR_PENALTY=0.
module tb_hazard_unit_p;

  localparam int BRP = 2;
  localparam int HD  = 3;

  logic        clk, rst;
  logic [15:0] if_id_instr, id_ex_instr;
  logic        if_id_valid, id_ex_memread, id_ex_valid;
  logic        stall, id_ex_bubble, halted;
  logic [1:0]  hazard_type;
  logic [2:0]  cycle_number, dbg_state;
  logic        stall0, bubble0, halted0;
  logic [1:0]  type0;
  logic [2:0]  cyc0, dbg0;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] load_cnt, ctrl_cnt, load_cnt0, ctrl_cnt0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit chk0 = 1'b1;
  bit m_halted = 1'b0;

  // One entry per upcoming cycle already committed by a branch/halt detect.
  typedef struct packed {
    logic       rel;
    logic [1:0] ty;
    logic [2:0] cyc;
    logic       last;
  } slot_t;
  slot_t exp_q[$];

  hazard_unit_p #(.INSTR_W(16), .REG_AW(4), .BR_PENALTY(BRP), .HLT_DRAIN(HD)) u_dut (
    .clk(clk), .rst(rst),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .id_ex_instr(id_ex_instr), .id_ex_memread(id_ex_memread), .id_ex_valid(id_ex_valid),
    .stall(stall), .id_ex_bubble(id_ex_bubble), .hazard_type(hazard_type),
    .cycle_number(cycle_number), .halted(halted),
`ifdef HAZARD_PERF_CNT_EN
    .load_stall_cnt(load_cnt), .ctrl_stall_cnt(ctrl_cnt),
`endif
    .dbg_state(dbg_state)
  );

  hazard_unit_p #(.INSTR_W(16), .REG_AW(4), .BR_PENALTY(0), .HLT_DRAIN(HD)) u_dut0 (
    .clk(clk), .rst(rst),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .id_ex_instr(id_ex_instr), .id_ex_memread(id_ex_memread), .id_ex_valid(id_ex_valid),
    .stall(stall0), .id_ex_bubble(bubble0), .hazard_type(type0),
    .cycle_number(cyc0), .halted(halted0),
`ifdef HAZARD_PERF_CNT_EN
    .load_stall_cnt(load_cnt0), .ctrl_stall_cnt(ctrl_cnt0),
`endif
    .dbg_state(dbg0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs, input logic [3:0] rt);
    return {op, rd, rs, rt};
  endfunction

  function automatic bit reads_reg(input logic [15:0] ins, input logic [3:0] r);
    int  op;
    bit  rs_rd, rt_rd, rd_rd;
    op    = int'(ins[15:12]);
    rs_rd = (op <= 9) || (op == 13);
    rt_rd = (op <= 3) || (op == 7);
    rd_rd = (op == 9) || (op == 10) || (op == 11);
    return (rs_rd && ins[7:4] == r) || (rt_rd && ins[3:0] == r) || (rd_rd && ins[11:8] == r);
  endfunction

  function automatic bit load_use(input logic [15:0] ifi, input logic ifv,
                                  input logic [15:0] exi, input logic exm, input logic exv);
    return ifv && exv && exm && (exi[11:8] != 4'd0) && reads_reg(ifi, exi[11:8]);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [15:0] ifi, input logic ifv,
                      input logic [15:0] exi, input logic exm, input logic exv);
    logic       s, h;
    logic [1:0] t;
    logic [2:0] c;
    bit         lu;
    slot_t      sl;
    if_id_instr   = ifi;
    if_id_valid   = ifv;
    id_ex_instr   = exi;
    id_ex_memread = exm;
    id_ex_valid   = exv;
    @(negedge clk);
    lu = load_use(ifi, ifv, exi, exm, exv);
    h = m_halted;
    s = 1'b0; t = 2'b00; c = 3'd0;
    if (m_halted) begin
      s = 1'b1; t = 2'b11;
    end else if (exp_q.size() > 0) begin
      sl = exp_q.pop_front();
      if (sl.rel) begin
        if (lu) begin s = 1'b1; t = 2'b01; end
      end else begin
        s = 1'b1; t = sl.ty; c = sl.cyc;
        if (sl.last) m_halted = 1'b1;
      end
    end else if (lu) begin
      s = 1'b1; t = 2'b01;
    end else if (ifv && (ifi[15:12] == 4'd12 || ifi[15:12] == 4'd13) && BRP > 0) begin
      s = 1'b1; t = 2'b10; c = 3'(BRP - 1);
      for (int k = BRP - 2; k >= 0; k--) exp_q.push_back('{1'b0, 2'b10, 3'(k), 1'b0});
      exp_q.push_back('{1'b1, 2'b00, 3'd0, 1'b0});
    end else if (ifv && ifi[15:12] == 4'd15) begin
      s = 1'b1; t = 2'b11; c = 3'(HD - 1);
      for (int k = HD - 2; k >= 0; k--) exp_q.push_back('{1'b0, 2'b11, 3'(k), (k == 0)});
      if (HD == 1) m_halted = 1'b1;
    end
    chk("stall", 16'(stall), 16'(s));
    chk("id_ex_bubble", 16'(id_ex_bubble), 16'(s));
    chk("hazard_type", 16'(hazard_type), 16'(t));
    chk("cycle_number", 16'(cycle_number), 16'(c));
    chk("halted", 16'(halted), 16'(h));
    if (chk0) begin
      chk("br0_stall", 16'(stall0), 16'(lu));
      chk("br0_type", 16'(type0), lu ? 16'd1 : 16'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    if_id_valid = 1'b0; id_ex_valid = 1'b0; id_ex_memread = 1'b0;
    if_id_instr = 16'd0; id_ex_instr = 16'd0;
    #1;
    exp_q.delete();
    m_halted = 1'b0;
    chk("rst_stall", 16'(stall), 16'd0);
    chk("rst_bubble", 16'(id_ex_bubble), 16'd0);
    chk("rst_type", 16'(hazard_type), 16'd0);
    chk("rst_cycle", 16'(cycle_number), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_load_cnt", load_cnt, 16'd0);
    chk("rst_ctrl_cnt", ctrl_cnt, 16'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] nop, add_r3, lw_r3, lw_r0, b_i, br_r5, lw_r5, hlt, ri, re;
    int halt_run;
    nop    = mk(4'd0, 4'd0, 4'd0, 4'd0);
    add_r3 = mk(4'd0, 4'd1, 4'd3, 4'd2);
    lw_r3  = mk(4'd8, 4'd3, 4'd0, 4'd0);
    lw_r0  = mk(4'd8, 4'd0, 4'd0, 4'd0);
    lw_r5  = mk(4'd8, 4'd5, 4'd0, 4'd0);
    b_i    = mk(4'd12, 4'd0, 4'd0, 4'd0);
    br_r5  = mk(4'd13, 4'd0, 4'd5, 4'd0);
    hlt    = mk(4'd15, 4'd0, 4'd0, 4'd0);

    do_reset();

    // load-use on rs, then with the LW gone; r0 destination never hazards
    step(add_r3, 1'b1, lw_r3, 1'b1, 1'b1);
    step(add_r3, 1'b1, nop, 1'b0, 1'b1);
    step(mk(4'd0, 4'd1, 4'd0, 4'd2), 1'b1, lw_r0, 1'b1, 1'b1);
    step(add_r3, 1'b0, lw_r3, 1'b1, 1'b1);
    step(add_r3, 1'b1, lw_r3, 1'b1, 1'b0);
    step(add_r3, 1'b1, lw_r3, 1'b0, 1'b1);
    step(mk(4'd7, 4'd1, 4'd0, 4'd3), 1'b1, lw_r3, 1'b1, 1'b1);
    step(mk(4'd4, 4'd1, 4'd0, 4'd3), 1'b1, lw_r3, 1'b1, 1'b1);
    step(mk(4'd9, 4'd3, 4'd0, 4'd0), 1'b1, lw_r3, 1'b1, 1'b1);
    step(mk(4'd10, 4'd3, 4'd0, 4'd0), 1'b1, lw_r3, 1'b1, 1'b1);
    step(b_i, 1'b1, lw_r3, 1'b1, 1'b1);

    // branch: two stall cycles, one release with the branch still present
    step(b_i, 1'b1, nop, 1'b0, 1'b1);
    step(b_i, 1'b1, nop, 1'b0, 1'b1);
    step(b_i, 1'b1, nop, 1'b0, 1'b1);
    step(nop, 1'b1, nop, 1'b0, 1'b1);

    // load-use wins over a simultaneous BR, branch sequence follows
    step(br_r5, 1'b1, lw_r5, 1'b1, 1'b1);
    step(br_r5, 1'b1, nop, 1'b0, 1'b1);
    step(br_r5, 1'b1, nop, 1'b0, 1'b1);
    step(br_r5, 1'b1, lw_r5, 1'b1, 1'b1);
    step(nop, 1'b1, nop, 1'b0, 1'b1);

    // reset in the middle of a control stall
    step(b_i, 1'b1, nop, 1'b0, 1'b1);
    chk("ctrl_before_rst", 16'(stall), 16'd1);
    do_reset();
    step(nop, 1'b1, nop, 1'b0, 1'b1);

    // halt drain then parked
    chk0 = 1'b0;
    step(hlt, 1'b1, nop, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) begin
      step(mk(4'($urandom_range(0, 15)), 4'd1, 4'd3, 4'd3), 1'b1, lw_r3, 1'b1, 1'b1);
    end
    do_reset();

    // random traffic over a small register range to provoke overlaps
    halt_run = 0;
    for (int i = 0; i < 400; i++) begin
      ri = mk(4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
              4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      if (ri[15:12] == 4'd15 && $urandom_range(0, 5) != 0) ri[15:12] = 4'd0;
      re = mk(4'd8, 4'($urandom_range(0, 3)), 4'd0, 4'd0);
      step(ri, 1'($urandom_range(0, 4) != 0), re, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 4) != 0));
      if (m_halted) halt_run++;
      if (halt_run > 4) begin
        do_reset();
        halt_run = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit_p.md
# hazard_unit_p

Parametrised pipeline hazard unit for the five-stage core, between the IF/ID and ID/EX pipeline registers. It detects load-use data hazards combinationally and sequences multi-cycle control stalls for B/BR and the HLT drain with an internal state machine and down-counter. It drives PC/IF-ID hold, ID/EX bubble insertion and a sticky halted flag. Optionally it keeps saturating stall counters.

## Interface
- INSTR_W, 16, instruction width; opcode is [INSTR_W-1:INSTR_W-4].
- REG_AW, 4, register index width; fields are rd [11:8], rs [7:4], rt [3:0] for the 16-bit ISA.
- BR_PENALTY, 2, stall cycles per B/BR (0..7); 0 disables control stalls.
- HLT_DRAIN, 3, cycles stalled after HLT before `halted` sets (1..7).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- if_id_instr  in  INSTR_W  instruction in IF/ID.
- if_id_valid  in  1  IF/ID holds a real instruction; 0 masks all detection.
- id_ex_instr  in  INSTR_W  instruction in ID/EX; the destination is rd [11:8].
- id_ex_memread  in  1  ID/EX instruction is LW.
- id_ex_valid  in  1  ID/EX holds a real instruction.
- stall  out  1  hold PC and IF/ID this cycle.
- id_ex_bubble  out  1  load NOP into ID/EX this cycle; equals stall.
- hazard_type  out  2  00 none, 01 load-use, 10 control, 11 halt.
- cycle_number  out  3  stall cycles remaining after the current one.
- halted  out  1  sticky; core stopped.

## Operation
- Source-use decode by opcode:
  - rs is read by 0000–1001 and 1101.
  - rt [3:0] is read by 0000–0011 and 0111.
  - rd [11:8] is read as a source by 1001 (SW data), 1010 and 1011.
- Load-use hazard: if_id_valid & id_ex_valid & id_ex_memread, the ID/EX rd is nonzero, and the rd equals any register the IF/ID instruction reads.
- Load-use is combinational and has top priority in IDLE. It asserts stall for exactly one cycle, then the LW advances. hazard_type = 01.
- States and behaviour:
  - IDLE: stall=0 unless load-use.
    - Otherwise, a valid B (1100) or BR (1101) with BR_PENALTY>0 asserts stall, loads cnt=BR_PENALTY-1, and goes to CTRL (cnt>0) or RELEASE (cnt==0).
    - Otherwise, a valid HLT (1111) asserts stall, loads cnt=HLT_DRAIN-1, and goes to DRAIN.
  - CTRL: stall=1, hazard_type=10, cnt decrements; RELEASE is entered when cnt==0.
  - RELEASE: stall=0 for one cycle with control and halt detection masked, so the held branch is not re-detected; load-use is still evaluated. Next state is IDLE.
  - DRAIN: stall=1, hazard_type=11, cnt decrements; at cnt==0 the next state is HALTED.
  - HALTED: stall=1, halted=1, hazard_type=11, cnt=0; the state stays until reset.
- cycle_number = cnt in CTRL/DRAIN and 0 otherwise. In the detecting IDLE cycle it shows the value being loaded.
- if_id_valid=0 or id_ex_valid=0 in IDLE: no load-use.

## Timing
- Reset (async assert, sync-safe deassert) sets the state to IDLE and cnt=0. Combinationally, stall and id_ex_bubble follow the IDLE rules; halted=0.
- Load-use: zero latency, exactly 1 stall cycle.
- Branch: exactly BR_PENALTY consecutive stall cycles starting on the detect cycle, then one RELEASE cycle.
- HLT: HLT_DRAIN stall cycles, then halted=1 from the next cycle onward.
- Simultaneous load-use and branch/HLT in IF/ID: load-use first. The control sequence starts the following IDLE cycle.
- Reset mid-CTRL/DRAIN/HALTED: the state returns to IDLE immediately and the count is discarded.

## Configuration
- HAZARD_PERF_CNT_EN:
  - Defined: adds output ports load_stall_cnt[15:0] and ctrl_stall_cnt[15:0]. Each is incremented once per stall cycle of its type (control includes DRAIN), saturates at 16'hFFFF, and resets to 0.
  - Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package hazard_pkg holds:
  - opcode constants (OP_LW, OP_SW, OP_B, OP_BR, OP_HLT, ...);
  - the state enum {IDLE, CTRL, RELEASE, DRAIN, HALTED};
  - hazard_type encodings;
  - the source-use decode function.
- One sub-module, hazard_stall_ctr: a loadable down-counter with a zero flag, used for cnt.

## Test plan
- LW r3 in ID/EX; ADD r1,r3,r2 in IF/ID → stall=1, hazard_type=01 for one cycle. With rd=r0 → stall=0.
- B in IF/ID, BR_PENALTY=2 → stall 1,1 with cycle_number 1,0 → RELEASE with stall=0 → IDLE.
- BR_PENALTY=0 with BR in IF/ID → stall never asserts.
- HLT in IF/ID, HLT_DRAIN=3 → 3 stall cycles, then halted=1 and stall=1 held for 10+ cycles.
- LW r5 in ID/EX with BR r5 in IF/ID → 1 load-use cycle, then 2 control stall cycles.
- rst low during CTRL at cnt=1 → IDLE and stall=0 immediately. With HAZARD_PERF_CNT_EN defined, the counters read 0.
